// File: rtl/sqrt_arb_pkg.sv
// Shared types and widths for the arbitrated 128-bit square-root datapath.
package sqrt_arb_pkg;

  localparam int OP_W  = 128;
  localparam int RES_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/sqrt_128b.sv
// Combinational floor square root of an unsigned 128-bit operand.
module sqrt_128b
  import sqrt_arb_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [RES_W-1:0] root
);

  logic [67:0]      rem;
  logic [67:0]      trial;
  logic [RES_W-1:0] r;
  logic [6:0]       idx;

  // Restoring digit-by-digit method: one result bit per operand bit pair, MSB first.
  always_comb begin
    rem   = '0;
    trial = '0;
    r     = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx   = 7'(2 * (63 - i));
      rem   = {rem[65:0], op[idx +: 2]};
      trial = {2'b00, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[RES_W-2:0], 1'b1};
      end else begin
        r   = {r[RES_W-2:0], 1'b0};
      end
    end
    root = r;
  end

endmodule

// File: rtl/sqrt_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sqrt_rr_pick #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] grant
);

  int unsigned     s;
  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate back towards ptr so the nearest one wins.
  always_comb begin
    any   = |req;
    grant = '0;
    s     = 0;
    idx   = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      s = 32'(ptr) + k - 1;
      if (s >= NREQ) s = s - NREQ;
      idx = ID_W'(s);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/sqrt_128b_arb.sv
// Round-robin arbiter sharing one combinational sqrt_128b among NREQ requesters,
// holding the operand SETTLE cycles before capturing the result.
module sqrt_128b_arb
  import sqrt_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 3,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt;

  logic             any;
  logic [ID_W-1:0]  grant;
  logic [OP_W-1:0]  op_sel;
  logic [RES_W-1:0] sqrt_out;

  sqrt_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .any   (any),
    .grant (grant)
  );

  sqrt_128b u_sqrt (op_q, sqrt_out);

  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) op_sel = req_data[i*OP_W +: OP_W];
    end
  end

  // Accept is gated by rst_n so nothing handshakes while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_q      <= '0;
      id_q      <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            op_q  <= op_sel;
            id_q  <= grant;
            cnt   <= CNT_W'(SETTLE - 1);
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_data  <= sqrt_out;
            res_id    <= id_q;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rr_ptr    <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_128b_arb.sv
// Directed self-checking bench for sqrt_128b_arb (NREQ=4, SETTLE=3).
module tb_sqrt_128b_arb;

  localparam int NREQ   = 4;
  localparam int SETTLE = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_data;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_data;
  logic [1:0]   res_id;
  logic         busy;

  int total;
  int bad;

  always #5 clk = ~clk;

  sqrt_128b_arb #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic do_reset;
    req_valid = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Enter one tick after a rising edge; return one tick after the edge that accepted.
  task automatic wait_grant(input bit drop, output int g, output bit ok);
    g  = -1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        ok = 1'b1;
        @(posedge clk);
        #1;
        if (drop) req_valid[g] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Returns two ticks after the edge of the first cycle with res_valid high.
  task automatic wait_res(output int lat, output bit ok);
    lat = -1;
    ok  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (res_valid) begin
        lat = n;
        ok  = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n             = 1'b0;
    res_ready         = 1'b1;
    req_valid         = 4'b0001;
    req_data[127:0]   = 128'd144;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_data !== 64'd0) begin bad++; $display("FAIL reset_res_data got=%0h want=0", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL reset_res_id got=%0d want=0", res_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b res_valid=%b want 0 0", busy, res_valid); end
  endtask

  task automatic test_single;
    int              g;
    int              lat;
    bit              ok;
    logic [127:0]    ops  [2];
    logic [63:0]     exps [2];
    ops[0] = 128'd144; exps[0] = 64'd12;
    ops[1] = 128'd15;  exps[1] = 64'd3;
    for (int k = 0; k < 2; k++) begin
      req_data[127:0] = ops[k];
      req_valid       = 4'b0001;
      wait_grant(1'b1, g, ok);
      total++; if (!ok || g != 0) begin bad++; $display("FAIL single_grant[%0d] ok=%0d id=%0d want id=0", k, ok, g); end
      if (!ok) return;
      wait_res(lat, ok);
      total++; if (!ok || lat != SETTLE) begin bad++; $display("FAIL single_latency[%0d] ok=%0d got=%0d want=%0d", k, ok, lat, SETTLE); end
      if (!ok) return;
      total++; if (res_data !== exps[k]) begin bad++; $display("FAIL single_data[%0d] got=%0d want=%0d", k, res_data, exps[k]); end
      total++; if (res_id !== 2'd0) begin bad++; $display("FAIL single_id[%0d] got=%0d want=0", k, res_id); end
      @(posedge clk);
      #1;
      total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle[%0d] res_valid=%b busy=%b want 0 0", k, res_valid, busy); end
    end
  endtask

  task automatic test_all_four;
    int           g;
    int           lat;
    bit           ok;
    logic [63:0]  exps [4];
    logic [127:0] big;
    do_reset();
    big = 128'd1;
    req_data[0*128 +: 128] = 128'd0;
    req_data[1*128 +: 128] = 128'd1;
    req_data[2*128 +: 128] = big << 64;
    req_data[3*128 +: 128] = '1;
    exps[0] = 64'd0;
    exps[1] = 64'd1;
    exps[2] = 64'h0000_0001_0000_0000;
    exps[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1'b1, g, ok);
      total++; if (!ok || g != k) begin bad++; $display("FAIL all4_grant[%0d] ok=%0d got=%0d want=%0d", k, ok, g, k); end
      if (!ok) return;
      wait_res(lat, ok);
      total++; if (!ok || res_data !== exps[k]) begin bad++; $display("FAIL all4_data[%0d] ok=%0d got=%0h want=%0h", k, ok, res_data, exps[k]); end
      if (!ok) return;
      total++; if (res_id !== 2'(k)) begin bad++; $display("FAIL all4_id[%0d] got=%0d want=%0d", k, res_id, k); end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    int g;
    int lat;
    bit ok;
    do_reset();
    res_ready              = 1'b0;
    req_data[0*128 +: 128] = 128'd10000;
    req_valid              = 4'b0001;
    wait_grant(1'b1, g, ok);
    total++; if (!ok || g != 0) begin bad++; $display("FAIL bp_grant ok=%0d got=%0d want=0", ok, g); end
    if (!ok) return;
    req_data[2*128 +: 128] = 128'd625;
    req_valid[2]           = 1'b1;
    wait_res(lat, ok);
    total++; if (!ok || res_data !== 64'd100) begin bad++; $display("FAIL bp_data ok=%0d got=%0d want=100", ok, res_data); end
    if (!ok) return;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== 64'd100 || res_id !== 2'd0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d] valid=%b data=%0d id=%0d ready=%b busy=%b want 1 100 0 0000 1",
                 c, res_valid, res_data, res_id, req_ready, busy);
      end
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b busy=%b want 0 0", res_valid, busy); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_next_ready got=%b want=0100", req_ready); end
    wait_grant(1'b1, g, ok);
    total++; if (!ok || g != 2) begin bad++; $display("FAIL bp_grant2 ok=%0d got=%0d want=2", ok, g); end
    if (!ok) return;
    wait_res(lat, ok);
    total++; if (!ok || res_data !== 64'd25 || res_id !== 2'd2) begin bad++; $display("FAIL bp_res2 ok=%0d data=%0d id=%0d want 25 2", ok, res_data, res_id); end
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic test_fairness;
    int g;
    int lat;
    bit ok;
    int prev;
    int want;
    do_reset();
    req_data[1*128 +: 128] = 128'd49;
    req_data[3*128 +: 128] = 128'd81;
    req_valid              = 4'b1010;
    prev                   = -1;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 1 : 3;
      wait_grant(1'b0, g, ok);
      total++; if (!ok || g != want) begin bad++; $display("FAIL fair_grant[%0d] ok=%0d got=%0d want=%0d", k, ok, g, want); end
      if (!ok) return;
      total++; if (g == prev) begin bad++; $display("FAIL fair_repeat[%0d] got=%0d want!=%0d", k, g, prev); end
      prev = g;
      wait_res(lat, ok);
      total++;
      if (!ok || res_data !== ((want == 1) ? 64'd7 : 64'd9) || res_id !== 2'(want)) begin
        bad++;
        $display("FAIL fair_res[%0d] ok=%0d data=%0d id=%0d want %0d %0d", k, ok, res_data, res_id, (want == 1) ? 7 : 9, want);
      end
      if (!ok) return;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_async_reset;
    int g;
    int lat;
    bit ok;
    int seen;
    do_reset();
    req_data[2*128 +: 128] = 128'd400;
    req_valid              = 4'b0100;
    wait_grant(1'b1, g, ok);
    total++; if (!ok || g != 2) begin bad++; $display("FAIL ar_first_grant ok=%0d got=%0d want=2", ok, g); end
    if (!ok) return;
    wait_res(lat, ok);
    total++; if (!ok || res_data !== 64'd20) begin bad++; $display("FAIL ar_first_data ok=%0d got=%0d want=20", ok, res_data); end
    if (!ok) return;
    @(posedge clk);
    #1;
    req_data[2*128 +: 128] = 128'd900;
    req_valid              = 4'b0100;
    wait_grant(1'b1, g, ok);
    total++; if (!ok || g != 2) begin bad++; $display("FAIL ar_second_grant ok=%0d got=%0d want=2", ok, g); end
    if (!ok) return;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 64'd0 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL ar_clear busy=%b valid=%b data=%0d id=%0d ready=%b want all 0", busy, res_valid, res_data, res_id, req_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL ar_no_result got=%0d want=0 valid cycles", seen); end
    req_data[1*128 +: 128] = 128'd121;
    req_data[3*128 +: 128] = 128'd169;
    req_valid              = 4'b1010;
    wait_grant(1'b1, g, ok);
    total++; if (!ok || g != 1) begin bad++; $display("FAIL ar_ptr_reset ok=%0d got=%0d want=1", ok, g); end
    if (!ok) return;
    req_valid = '0;
    wait_res(lat, ok);
    total++; if (!ok || res_data !== 64'd11 || res_id !== 2'd1) begin bad++; $display("FAIL ar_after_res ok=%0d data=%0d id=%0d want 11 1", ok, res_data, res_id); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
